axis_read_data: RTL and testbench

AXIS_READ_DATA -- requirements
Module: axis_read_data

---
 rtl/axis_read_data_pkg.sv | 7 +
 rtl/axis_read_data_fifo_simple.sv | 39 +++
 rtl/axis_read_data.sv | 71 +++++++
 tb/tb_axis_read_data.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_read_data_pkg.sv
// axis_read_data_pkg: shared stream FSM states and AXI-to-stream width ratio helper
package axis_read_data_pkg;
  typedef enum logic {CONFIG = 1'b0, ACTIVE = 1'b1} state_t;
  function automatic int width_ratio(input int axi_width, input int data_width);
    return axi_width / data_width;
  endfunction
endpackage

// File: rtl/axis_read_data_fifo_simple.sv
// fifo_simple: register-array FIFO whose head word is read straight from storage
module fifo_simple #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = cnt == DEPTH[ADDR_WIDTH:0];
  assign empty   = cnt == '0;
  assign head    = mem[rd_ptr];
  // storage is not reset; occupancy alone decides what is live
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at the array depth; reset flushes the queue
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      cnt <= cnt + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
    end
endmodule

// File: rtl/axis_read_data.sv
// axis_read_data: buffers AXI read beats and streams them out as narrower words for a configured length
module axis_read_data
  import axis_read_data_pkg::*;
#(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int CONVERT_SHIFT  = 1,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready
);
  localparam int RATIO = width_ratio(AXI_DATA_WIDTH, DATA_WIDTH);
  state_t                              state;
  logic [CFG_DWIDTH-1:0]               str_cnt;
  logic [CONVERT_SHIFT-1:0]            lane;
  logic [AXI_DATA_WIDTH-1:0]           head;
  logic [RATIO-1:0][DATA_WIDTH-1:0]    lanes;
  logic full, empty, push, pop, fire, last_word, unused_rlast;
  assign unused_rlast = axi_rlast;
  assign axi_rready   = !full;
  assign push         = axi_rvalid && axi_rready;
  assign cfg_rdy      = state == CONFIG;
  assign last_word    = str_cnt == CFG_DWIDTH'(1);
  assign valid        = state == ACTIVE && !empty && str_cnt != '0;
  assign fire         = valid && ready;
  assign pop          = fire && (&lane || last_word);
  assign lanes        = head;
  assign data         = valid ? lanes[lane] : '0;
  fifo_simple #(
    .DATA_WIDTH(AXI_DATA_WIDTH),
    .ADDR_WIDTH(BUF_AWIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (axi_rdata),
    .pop  (pop),
    .head (head),
    .full (full),
    .empty(empty)
  );
  // transfer FSM: zero-length configs are ignored; last word drops any unused lanes of its beat
  always_ff @(posedge clk)
    if (rst) begin
      state   <= CONFIG;
      str_cnt <= '0;
      lane    <= '0;
    end else if (state == CONFIG) begin
      if (cfg_val && cfg_length != '0) begin
        state   <= ACTIVE;
        str_cnt <= cfg_length;
        lane    <= '0;
      end
    end else if (fire) begin
      str_cnt <= str_cnt - CFG_DWIDTH'(1);
      lane    <= last_word ? '0 : lane + CONVERT_SHIFT'(1);
      if (last_word) state <= CONFIG;
    end
endmodule

// File: tb/tb_axis_read_data.sv
// tb_axis_read_data: directed scenario tests for the AXI-to-stream read data path
module tb_axis_read_data;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [63:0] axi_rdata;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] got_w [16];
  int          got_n;
  int          span;

  always #5 clk = ~clk;

  axis_read_data dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_length(cfg_length),
    .cfg_val   (cfg_val),
    .cfg_rdy   (cfg_rdy),
    .axi_rdata (axi_rdata),
    .axi_rlast (axi_rlast),
    .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .data      (data),
    .valid     (valid),
    .ready     (ready)
  );

  function automatic logic [63:0] mk(input int i);
    return {32'(2 * i + 2), 32'(2 * i + 1)};
  endfunction

  task automatic push_beat(input logic [63:0] b);
    axi_rvalid = 1'b1;
    axi_rdata  = b;
    @(negedge clk);
    axi_rvalid = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] len);
    cfg_length = len;
    cfg_val    = 1'b1;
    @(negedge clk);
    cfg_val = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect(input int n, input bit toggle);
    int first, last;
    got_n = 0;
    first = -1;
    last  = -1;
    for (int c = 0; c < 200; c++) begin
      ready = toggle ? ~c[0] : 1'b1;
      if (valid && ready) begin
        if (got_n < 16) got_w[got_n] = data;
        if (first < 0) first = c;
        last = c;
        got_n++;
      end
      @(negedge clk);
      if (got_n >= n) break;
    end
    ready = 1'b0;
    span  = last - first + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL reset_cfg_rdy got=%b exp=1", cfg_rdy); end
    checks++; if (axi_rready !== 1'b1) begin failures++; $display("FAIL reset_axi_rready got=%b exp=1", axi_rready); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cfg(8);
    for (int i = 0; i < 4; i++) push_beat(mk(i));
    collect(8, 1'b0);
    checks++; if (got_n !== 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_w[i] !== 32'(i + 1)) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_w[i], i + 1); end
    end
    checks++; if (span !== 8) begin failures++; $display("FAIL basic_span got=%0d exp=8", span); end
    checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL basic_cfg_rdy got=%b exp=1", cfg_rdy); end
  endtask

  task automatic test_odd_length();
    cfg(7);
    for (int i = 0; i < 4; i++) push_beat(mk(i));
    collect(7, 1'b0);
    checks++; if (got_n !== 7) begin failures++; $display("FAIL odd_count got=%0d exp=7", got_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (got_w[i] !== 32'(i + 1)) begin failures++; $display("FAIL odd_word%0d got=%h exp=%h", i, got_w[i], i + 1); end
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL odd_done_valid got=%b exp=0", valid); end
    cfg(2);
    push_beat(mk(4));
    collect(2, 1'b0);
    checks++; if (got_w[0] !== 32'h9) begin failures++; $display("FAIL odd_next0 got=%h exp=9", got_w[0]); end
    checks++; if (got_w[1] !== 32'hA) begin failures++; $display("FAIL odd_next1 got=%h exp=a", got_w[1]); end
  endtask

  task automatic test_zero_length();
    push_beat(mk(0));
    cfg(0);
    checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL zero_cfg_rdy got=%b exp=1", cfg_rdy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL zero_valid got=%b exp=0", valid); end
    cfg(2);
    collect(2, 1'b0);
    checks++; if (got_w[0] !== 32'h1) begin failures++; $display("FAIL zero_then0 got=%h exp=1", got_w[0]); end
    checks++; if (got_w[1] !== 32'h2) begin failures++; $display("FAIL zero_then1 got=%h exp=2", got_w[1]); end
  endtask

  task automatic test_backpressure();
    cfg(8);
    for (int i = 0; i < 4; i++) push_beat(mk(i));
    collect(8, 1'b1);
    checks++; if (got_n !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_w[i] !== 32'(i + 1)) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_w[i], i + 1); end
    end
    checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL bp_cfg_rdy got=%b exp=1", cfg_rdy); end
  endtask

  task automatic test_full();
    int acc;
    cfg(64);
    ready      = 1'b0;
    acc        = 0;
    axi_rdata  = mk(0);
    axi_rvalid = 1'b1;
    for (int c = 0; c < 40 && axi_rready; c++) begin
      acc++;
      @(negedge clk);
      axi_rdata = mk(acc);
    end
    checks++; if (acc !== 16) begin failures++; $display("FAIL full_accepted got=%0d exp=16", acc); end
    checks++; if (axi_rready !== 1'b0) begin failures++; $display("FAIL full_rready_low got=%b exp=0", axi_rready); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", valid); end
    ready = 1'b1;
    checks++; if (data !== 32'h1) begin failures++; $display("FAIL full_data0 got=%h exp=1", data); end
    @(negedge clk);
    checks++; if (axi_rready !== 1'b0) begin failures++; $display("FAIL full_rready_prepop got=%b exp=0", axi_rready); end
    checks++; if (data !== 32'h2) begin failures++; $display("FAIL full_data1 got=%h exp=2", data); end
    @(negedge clk);
    ready      = 1'b0;
    axi_rvalid = 1'b0;
    checks++; if (axi_rready !== 1'b1) begin failures++; $display("FAIL full_rready_after_pop got=%b exp=1", axi_rready); end
    do_reset();
  endtask

  task automatic test_early_data();
    push_beat(mk(0));
    push_beat(mk(1));
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL early_valid_config got=%b exp=0", valid); end
    cfg(4);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL early_valid_active got=%b exp=1", valid); end
    checks++; if (data !== 32'h1) begin failures++; $display("FAIL early_first_data got=%h exp=1", data); end
    collect(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_w[i] !== 32'(i + 1)) begin failures++; $display("FAIL early_word%0d got=%h exp=%h", i, got_w[i], i + 1); end
    end
  endtask

  task automatic test_reset_mid();
    cfg(8);
    for (int i = 0; i < 4; i++) push_beat(mk(i));
    collect(3, 1'b0);
    checks++; if (got_n !== 3) begin failures++; $display("FAIL mid_count got=%0d exp=3", got_n); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", valid); end
    checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL mid_rst_cfg_rdy got=%b exp=1", cfg_rdy); end
    checks++; if (axi_rready !== 1'b1) begin failures++; $display("FAIL mid_rst_rready got=%b exp=1", axi_rready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_after_valid got=%b exp=0", valid); end
    checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL mid_after_cfg_rdy got=%b exp=1", cfg_rdy); end
    cfg(2);
    push_beat({32'hB, 32'hA});
    collect(2, 1'b0);
    checks++; if (got_n !== 2) begin failures++; $display("FAIL mid_next_count got=%0d exp=2", got_n); end
    checks++; if (got_w[0] !== 32'hA) begin failures++; $display("FAIL mid_next0 got=%h exp=a", got_w[0]); end
    checks++; if (got_w[1] !== 32'hB) begin failures++; $display("FAIL mid_next1 got=%h exp=b", got_w[1]); end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_length = '0;
    cfg_val    = 1'b0;
    axi_rdata  = '0;
    axi_rlast  = 1'b0;
    axi_rvalid = 1'b0;
    ready      = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_odd_length();
    test_zero_length();
    test_backpressure();
    test_full();
    test_early_data();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
